// File: rtl/sseg_pkg.sv
// Shared definitions for the 7-segment scan monitor: segment patterns (a..g, MSB = a),
// FSM state encoding and the polarity normalisation helpers.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HELD   = 2'd2
  } state_t;

  // Bring the raw bus to "1 = lit / 1 = selected" regardless of board polarity.
  function automatic logic [6:0] norm_seg(input logic [6:0] raw, input bit active_low);
    return active_low ? ~raw : raw;
  endfunction

  function automatic logic [3:0] norm_an(input logic [3:0] raw, input bit active_low);
    return active_low ? ~raw : raw;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/sseg_capture_if.sv
// Scan bus plus decoded-frame results; master drives the display lines, slave is the monitor.
interface sseg_capture_if;

  logic [0:6]  SSeg;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        frame_err;
  logic        stale;

  modport master (
    output SSeg,
    output an,
    input  value,
    input  blank,
    input  frame_valid,
    input  frame_err,
    input  stale
  );

  modport slave (
    input  SSeg,
    input  an,
    output value,
    output blank,
    output frame_valid,
    output frame_err,
    output stale
  );

endinterface

// File: rtl/sseg_pattern_decode.sv
// Combinational inverse of the BCD->7-seg table; all-off is reported as blank, anything
// outside the table as invalid.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       is_blank,
  output logic       invalid
);

  always_comb begin
    nibble   = 4'h0;
    is_blank = 1'b0;
    invalid  = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: is_blank = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/sseg_capture.sv
// Watches a multiplexed 7-segment scan, accepts each digit once it has been stable, and
// publishes complete 4-digit frames; partial frames are dropped after a quiet timeout.
module sseg_capture
  import sseg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  sseg_capture_if.slave bus
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_FULL = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  logic [6:0] seg_raw_q;
  logic [3:0] an_raw_q;
  logic [6:0] seg_s;
  logic [3:0] an_s;
  logic       an_legal;
  logic [1:0] slot_idx;
  logic       same_as_ref;

  state_t            state, state_nx;
  logic [STAB_W-1:0] stab_cnt, stab_nx;
  logic [3:0]        ref_an, ref_an_nx;
  logic [6:0]        ref_seg, ref_seg_nx;
  logic              accept;

  logic [3:0] dec_nibble;
  logic       dec_blank;
  logic       dec_invalid;

  logic [15:0]     dig_q;
  logic [3:0]      seen, seen_nx;
  logic [3:0]      blank_acc, blank_acc_nx;
  logic            err_acc, err_acc_nx;
  logic [TO_W-1:0] to_cnt;
  logic            frame_done;
  logic            to_expire;
  logic            clear_partial;
  logic [3:0]      slot_mask;

  logic [15:0] value_q;
  logic [3:0]  blank_q;
  logic        frame_valid_q;
  logic        frame_err_q;
  logic        stale_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_raw_q <= 7'd0;
      an_raw_q  <= 4'd0;
    end else begin
      seg_raw_q <= bus.SSeg;
      an_raw_q  <= bus.an;
    end
  end

  assign seg_s       = norm_seg(seg_raw_q, SEG_ACTIVE_LOW);
  assign an_s        = norm_an(an_raw_q, AN_ACTIVE_LOW);
  assign an_legal    = is_onehot4(an_s);
  assign same_as_ref = (an_s == ref_an) && (seg_s == ref_seg);

  always_comb begin
    slot_idx = 2'd0;
    case (an_s)
      4'b0010: slot_idx = 2'd1;
      4'b0100: slot_idx = 2'd2;
      4'b1000: slot_idx = 2'd3;
      default: slot_idx = 2'd0;
    endcase
  end

  sseg_pattern_decode u_decode (
    .pattern  (seg_s),
    .nibble   (dec_nibble),
    .is_blank (dec_blank),
    .invalid  (dec_invalid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_WAIT;
      stab_cnt <= '0;
      ref_an   <= 4'd0;
      ref_seg  <= 7'd0;
    end else begin
      state    <= state_nx;
      stab_cnt <= stab_nx;
      ref_an   <= ref_an_nx;
      ref_seg  <= ref_seg_nx;
    end
  end

  // An illegal anode always wins; otherwise any change of (an, seg) restarts the settle count.
  always_comb begin
    state_nx   = state;
    stab_nx    = stab_cnt;
    ref_an_nx  = ref_an;
    ref_seg_nx = ref_seg;
    accept     = 1'b0;
    if (!an_legal) begin
      state_nx = S_WAIT;
      stab_nx  = '0;
    end else begin
      case (state)
        S_WAIT: begin
          state_nx   = S_SETTLE;
          stab_nx    = STAB_ONE;
          ref_an_nx  = an_s;
          ref_seg_nx = seg_s;
        end
        S_SETTLE: begin
          if (same_as_ref) begin
            if (stab_cnt == STAB_LAST) begin
              accept   = 1'b1;
              state_nx = S_HELD;
              stab_nx  = STAB_FULL;
            end else begin
              stab_nx = stab_cnt + STAB_ONE;
            end
          end else begin
            stab_nx    = STAB_ONE;
            ref_an_nx  = an_s;
            ref_seg_nx = seg_s;
          end
        end
        S_HELD: begin
          if (!same_as_ref) begin
            state_nx   = S_SETTLE;
            stab_nx    = STAB_ONE;
            ref_an_nx  = an_s;
            ref_seg_nx = seg_s;
          end
        end
        default: begin
          state_nx = S_WAIT;
          stab_nx  = '0;
        end
      endcase
    end
  end

  // Completion and timeout both wipe the partial frame; an accept this cycle lands on top.
  always_comb begin
    frame_done    = (seen == 4'hF);
    to_expire     = (to_cnt == TO_LAST) && !accept;
    clear_partial = frame_done || to_expire;
    slot_mask     = accept ? an_s : 4'd0;
    seen_nx       = (clear_partial ? 4'd0 : seen) | slot_mask;
    blank_acc_nx  = ((clear_partial ? 4'd0 : blank_acc) & ~slot_mask)
                  | (dec_blank ? slot_mask : 4'd0);
    err_acc_nx    = (clear_partial ? 1'b0 : err_acc) | (accept & dec_invalid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_q     <= 16'd0;
      seen      <= 4'd0;
      blank_acc <= 4'd0;
      err_acc   <= 1'b0;
    end else begin
      seen      <= seen_nx;
      blank_acc <= blank_acc_nx;
      err_acc   <= err_acc_nx;
      if (accept) begin
        dig_q[{slot_idx, 2'b00} +: 4] <= dec_nibble;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt  <= '0;
      stale_q <= 1'b0;
    end else if (accept) begin
      to_cnt  <= '0;
      stale_q <= 1'b0;
    end else if (to_cnt == TO_LAST) begin
      stale_q <= 1'b1;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q       <= 16'd0;
      blank_q       <= 4'd0;
      frame_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= frame_done;
      if (frame_done) begin
        value_q     <= dig_q;
        blank_q     <= blank_acc;
        frame_err_q <= err_acc;
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.blank       = blank_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.stale       = stale_q;

endmodule

// File: doc/sseg_capture.md
Name: sseg_capture

Overview:
- Monitor/decoder for the multiplexed 7-segment display bus: the receiving end of the BCD→7-seg + anode-scan path.
- Samples SSeg/an, waits for each digit slot to settle, decodes each segment pattern back to a 4-bit hex digit, and assembles a 4-digit frame.
- Placed beside the display top (or in benches) so the displayed value can be checked as a number.
- Single clock domain; scan inputs are synchronous to clk.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = a segment is lit when its SSeg bit is 0.
- AN_ACTIVE_LOW, 1, 1 = a digit is selected when its an bit is 0.
- STABLE_CYCLES, 4, consecutive identical samples needed before a digit is accepted (≥2).
- TIMEOUT_CYCLES, 4096, clocks with no accepted digit before the partial frame is declared stale.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- SSeg  input  [0:6]  segment bus; bit 0 = segment a … bit 6 = segment g.
- an  input  [3:0]  anode select; an[k] selects digit k.
- value  output  [15:0]  last complete frame; value[4k+3:4k] = digit k.
- blank  output  [3:0]  blank[k]=1 when digit k was all-off in the last frame.
- frame_valid  output  1  one-cycle pulse when value/blank/frame_err update.
- frame_err  output  1  last frame contained an undecodable pattern.
- stale  output  1  no digit accepted for TIMEOUT_CYCLES.

Behaviour:
- Reset (rst=0, async): value=0, blank=4'b0000, frame_valid=0, frame_err=0, stale=0, seen=0, FSM=S_WAIT, counters=0.
- Input stage:
  - SSeg and an are registered once (1-cycle latency).
  - Both are normalised to active-high using the polarity parameters.
- Anode legality: the normalised an must be one-hot.
  - 0 or ≥2 bits set: FSM→S_WAIT; the stability counter clears.
  - seen and the timeout counter are not affected.
- FSM states and transitions:
  - S_WAIT: on a legal one-hot an → S_SETTLE, stab_cnt=1, latch (an, seg) as reference.
  - S_SETTLE: sample == reference → stab_cnt+1. Sample differs but an still legal → re-latch reference, stab_cnt=1.
    - When stab_cnt reaches STABLE_CYCLES, in the same cycle: accept the digit, then → S_HELD.
    - Accept = store decoded nibble in dig[idx], blank_acc[idx], err_acc |= invalid, seen[idx]=1, timeout counter cleared; idx = position of the one-hot bit.
  - S_HELD: no re-accept while (an, seg) is unchanged. Any change → S_SETTLE (new reference, stab_cnt=1), or → S_WAIT if an is illegal.
- Decode, pattern written as a..g with 1 = lit:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - 0000000 = blank: nibble 0, blank bit set, not an error.
  - Any other pattern: nibble 0, invalid=1.
- Frame completion: when seen becomes 4'b1111 (including on the accepting cycle), on the next clock:
  - value ← dig, blank ← blank_acc, frame_err ← err_acc, frame_valid=1 for exactly one cycle.
  - seen, err_acc and blank_acc clear.
- Re-accept before completion: the same slot accepted again before the frame completes overwrites its digit. This is legal; the newest sample wins.
- Timeout: the counter increments every cycle and clears on accept.
  - On reaching TIMEOUT_CYCLES-1: stale=1, seen/err_acc/blank_acc clear, counter holds.
  - stale clears on the next accepted digit.
  - value is not modified by a timeout.
- Simultaneous events: if accept and timeout coincide, accept wins (counter clears, stale not set).
- Reset mid-frame discards partial digits. value returns to 0.

Decomposition:
- Package sseg_pkg holds:
  - segment-pattern constants SEG_0…SEG_F and SEG_BLANK (7 bits, a..g order);
  - FSM state encodings S_WAIT/S_SETTLE/S_HELD;
  - the polarity normalisation helper.
- One sub-module: sseg_pattern_decode. Purely combinational: 7-bit pattern in; nibble, is_blank and invalid out.
- The FSM, counters and frame assembly stay in sseg_capture.

Test Plan:
- Reset: rst=0 for 3 cycles with random inputs → value=0x0000, blank=0, frame_valid/frame_err/stale=0; release → still 0 until 4 digits accepted.
- Scan 1,2,3,4: an=1110,1101,1011,0111 (active-low), each held 8 cycles, SSeg=~pattern for digits 4,3,2,1 respectively → one frame_valid pulse, value=0x1234, blank=0, frame_err=0.
- Glitch/settle: digit slot 0 shows "7" for 3 cycles then "8" for 8 cycles (STABLE_CYCLES=4) → digit 0 captured as 8; no accept occurs during the 3-cycle "7".
- Blank and error: slot 3 all segments off, slot 2 pattern 0000001 (g only), slots 1/0 show A and F → value=0x00AF, blank=1000, frame_err=1.
- Illegal anode: an=1100 for 20 cycles between valid slots → no accept, FSM in S_WAIT; the frame still completes correctly once legal scanning resumes.
- Timeout: two digits accepted, then an=1111 for TIMEOUT_CYCLES → stale=1, partial frame discarded; a subsequent full scan of 5,6,7,8 → value=0x5678 (no mixing of old digits), stale=0.
